// File: rtl/lives_pkg.sv
// rtl/lives_pkg.sv - shared types, constants and 7-segment helper for the lives tracker
package lives_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        INVULN    = 2'd2,
        GAME_OVER = 2'd3
    } lives_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows blank.
    function automatic logic [6:0] seg7_digit(input int value);
        logic [6:0] seg;
        case (value)
            0:       seg = 7'b1000000;
            1:       seg = 7'b1111001;
            2:       seg = 7'b0100100;
            3:       seg = 7'b0110000;
            4:       seg = 7'b0011001;
            5:       seg = 7'b0010010;
            6:       seg = 7'b0000010;
            7:       seg = 7'b1111000;
            8:       seg = 7'b0000000;
            9:       seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational 4-bit to active-low 7-segment decode
module seg7_decoder
    import lives_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup, shared with the score display.
    always_comb begin
        seg = seg7_digit(int'(digit));
    end

endmodule

// File: rtl/lives_tracker.sv
// rtl/lives_tracker.sv - life counter FSM with invulnerability window and blinking digit
module lives_tracker
    import lives_pkg::*;
#(
    parameter int MAX_LIVES     = 3,
    parameter int START_LIVES   = 3,
    parameter int INVULN_CYCLES = 50000000,
    parameter int BLINK_CYCLES  = 12500000,
    localparam int LW           = $clog2(MAX_LIVES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          hit,
    input  logic          bonus,
    output logic [LW-1:0] lives,
    output logic [6:0]    display,
    output logic          invulnerable,
    output logic          game_over,
    output logic          life_lost
);

    localparam int IW = $clog2(INVULN_CYCLES);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    localparam logic [LW-1:0] START_L     = LW'(START_LIVES);
    localparam logic [LW-1:0] MAX_L       = LW'(MAX_LIVES);
    localparam logic [IW-1:0] INVULN_LAST = IW'(INVULN_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_CYCLES - 1);

    lives_state_e  state_q, state_d;
    logic [LW-1:0] lives_q, lives_d;
    logic [IW-1:0] invuln_cnt_q, invuln_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [6:0]    display_q, display_d;
    logic          invulnerable_q, invulnerable_d;
    logic          game_over_q, game_over_d;
    logic          life_lost_q, life_lost_d;

    logic [LW-1:0] lives_inc;
    logic [6:0]    digit_seg;

    // Bonus never pushes the count past the ceiling.
    assign lives_inc = (lives_q >= MAX_L) ? lives_q : lives_q + LW'(1);

    seg7_decoder u_seg7 (
        .digit (4'(lives_d)),
        .seg   (digit_seg)
    );

    // Next-state, count, timers and the registered view of the next values.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        invuln_cnt_d = invuln_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        blink_ph_d   = blink_ph_q;
        life_lost_d  = 1'b0;

        if (start) begin
            state_d      = PLAY;
            lives_d      = START_L;
            invuln_cnt_d = '0;
            blink_cnt_d  = '0;
            blink_ph_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                PLAY: begin
                    if (hit && !bonus) begin
                        // lives_q is never 0 in PLAY, but guard the underflow anyway.
                        lives_d     = (lives_q == '0) ? '0 : lives_q - LW'(1);
                        life_lost_d = (lives_q != '0);
                        if (lives_d == '0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d      = INVULN;
                            invuln_cnt_d = INVULN_LAST;
                            blink_cnt_d  = '0;
                            blink_ph_d   = 1'b0;
                        end
                    end else if (bonus && !hit) begin
                        lives_d = lives_inc;
                    end
                end
                INVULN: begin
                    if (bonus) begin
                        lives_d = lives_inc;
                    end
                    if (invuln_cnt_q == '0) begin
                        state_d     = PLAY;
                        blink_cnt_d = '0;
                        blink_ph_d  = 1'b0;
                    end else begin
                        invuln_cnt_d = invuln_cnt_q - IW'(1);
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_d = '0;
                            blink_ph_d  = ~blink_ph_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + BW'(1);
                        end
                    end
                end
                GAME_OVER: begin
                    lives_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        invulnerable_d = (state_d == INVULN);
        game_over_d    = (state_d == GAME_OVER);
        display_d      = (invulnerable_d && blink_ph_d) ? SEG_BLANK : digit_seg;
    end

    // State and output registers with asynchronous return to the power-on values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            lives_q        <= START_L;
            invuln_cnt_q   <= '0;
            blink_cnt_q    <= '0;
            blink_ph_q     <= 1'b0;
            display_q      <= seg7_digit(START_LIVES);
            invulnerable_q <= 1'b0;
            game_over_q    <= 1'b0;
            life_lost_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            invuln_cnt_q   <= invuln_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_ph_q     <= blink_ph_d;
            display_q      <= display_d;
            invulnerable_q <= invulnerable_d;
            game_over_q    <= game_over_d;
            life_lost_q    <= life_lost_d;
        end
    end

    assign lives        = lives_q;
    assign display      = display_q;
    assign invulnerable = invulnerable_q;
    assign game_over    = game_over_q;
    assign life_lost    = life_lost_q;

endmodule

// File: tb/tb_lives_tracker.sv
// tb/tb_lives_tracker.sv - self-checking bench for lives_tracker
module tb_lives_tracker;

    localparam int MAXL   = 3;
    localparam int STARTL = 3;
    localparam int INVC   = 8;
    localparam int BLINKC = 2;
    localparam int LW     = $clog2(MAXL + 1);

    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] D0    = 7'b1000000;
    localparam logic [6:0] D2    = 7'b0100100;
    localparam logic [6:0] D3    = 7'b0110000;

    localparam int M_IDLE = 0;
    localparam int M_PLAY = 1;
    localparam int M_INV  = 2;
    localparam int M_OVER = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic          hit;
    logic          bonus;
    logic [LW-1:0] lives;
    logic [6:0]    display;
    logic          invulnerable;
    logic          game_over;
    logic          life_lost;

    int n_cmp;
    int n_bad;

    logic [6:0] seg_tab [0:9];

    int m_mode;
    int m_lives;
    int m_elapsed;
    int m_lost;

    lives_tracker #(
        .MAX_LIVES     (MAXL),
        .START_LIVES   (STARTL),
        .INVULN_CYCLES (INVC),
        .BLINK_CYCLES  (BLINKC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .hit          (hit),
        .bonus        (bonus),
        .lives        (lives),
        .display      (display),
        .invulnerable (invulnerable),
        .game_over    (game_over),
        .life_lost    (life_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: mode, count and time since the hit that opened the window.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode    = M_IDLE;
            m_lives   = STARTL;
            m_elapsed = 0;
            m_lost    = 0;
        end else begin
            m_lost = 0;
            if (start) begin
                m_mode  = M_PLAY;
                m_lives = STARTL;
            end else if (m_mode == M_PLAY) begin
                if (hit && !bonus) begin
                    m_lives = m_lives - 1;
                    m_lost  = 1;
                    if (m_lives == 0) begin
                        m_mode = M_OVER;
                    end else begin
                        m_mode    = M_INV;
                        m_elapsed = 0;
                    end
                end else if (bonus && !hit && m_lives < MAXL) begin
                    m_lives = m_lives + 1;
                end
            end else if (m_mode == M_INV) begin
                if (bonus && m_lives < MAXL) m_lives = m_lives + 1;
                m_elapsed = m_elapsed + 1;
                if (m_elapsed >= INVC) m_mode = M_PLAY;
            end
        end
    end

    function automatic logic [6:0] model_display();
        if (m_mode == M_INV && ((m_elapsed / BLINKC) % 2) == 1) return BLANK;
        return seg_tab[m_lives];
    endfunction

    // Every cycle, mid-period, all outputs against the reference.
    always @(negedge clk) begin
        check("lives", 32'(lives), 32'(m_lives));
        check("display", 32'(display), 32'(model_display()));
        check("invulnerable", 32'(invulnerable), 32'(m_mode == M_INV));
        check("game_over", 32'(game_over), 32'(m_mode == M_OVER));
        check("life_lost", 32'(life_lost), 32'(m_lost));
    end

    task automatic step(input logic s, input logic h, input logic b);
        @(negedge clk);
        start = s;
        hit   = h;
        bonus = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        hit   = 1'b0;
        bonus = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [6:0] disp_seq [0:19];
    logic       ll_seq   [0:19];
    int         inv_n;

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
        seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0010000;
        n_cmp = 0;
        n_bad = 0;
        start = 1'b0;
        hit   = 1'b0;
        bonus = 1'b0;
        reset = 1'b1;
        #23;
        reset = 1'b0;
        #1;
        check("lit_reset_lives", 32'(lives), 32'd3);
        check("lit_reset_display", 32'(display), 32'(D3));
        check("lit_reset_inv", 32'(invulnerable), 32'd0);
        check("lit_reset_go", 32'(game_over), 32'd0);

        // 1. start
        step(1'b0, 1'b1, 1'b1);
        check("lit_idle_ignores", 32'(lives), 32'd3);
        step(1'b1, 1'b0, 1'b0);
        check("lit_start_lives", 32'(lives), 32'd3);
        check("lit_start_display", 32'(display), 32'(D3));
        check("lit_start_go", 32'(game_over), 32'd0);

        // 2. hit, window length and blink pattern
        step(1'b0, 1'b1, 1'b0);
        check("lit_hit_lives", 32'(lives), 32'd2);
        check("lit_hit_lost", 32'(life_lost), 32'd1);
        inv_n = 0;
        for (int i = 0; i < 20; i++) begin
            disp_seq[i] = display;
            ll_seq[i]   = life_lost;
            if (invulnerable) inv_n++;
            step(1'b0, 1'b0, 1'b0);
        end
        check("lit_inv_cycles", 32'(inv_n), 32'd8);
        check("lit_lost_one_cycle", 32'(ll_seq[1]), 32'd0);
        check("lit_blink0", 32'(disp_seq[0]), 32'(D2));
        check("lit_blink1", 32'(disp_seq[1]), 32'(D2));
        check("lit_blink2", 32'(disp_seq[2]), 32'(BLANK));
        check("lit_blink3", 32'(disp_seq[3]), 32'(BLANK));
        check("lit_blink4", 32'(disp_seq[4]), 32'(D2));
        check("lit_blink8", 32'(disp_seq[8]), 32'(D2));

        // 3. hits ignored and bonus saturating during the window
        step(1'b0, 1'b0, 1'b1);
        check("lit_bonus_play", 32'(lives), 32'd3);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("lit_inv_hit_lives", 32'(lives), 32'd2);
        check("lit_inv_hit_lost", 32'(life_lost), 32'd0);
        step(1'b0, 1'b0, 1'b1);
        check("lit_inv_bonus", 32'(lives), 32'd3);
        step(1'b0, 1'b0, 1'b1);
        check("lit_inv_bonus_sat", 32'(lives), 32'd3);
        idle(10);

        // 4. hit and bonus cancel
        step(1'b0, 1'b1, 1'b1);
        check("lit_cancel_lives", 32'(lives), 32'd3);
        check("lit_cancel_lost", 32'(life_lost), 32'd0);
        check("lit_cancel_inv", 32'(invulnerable), 32'd0);

        // 5. run down to game over
        step(1'b0, 1'b1, 1'b0);
        idle(10);
        step(1'b0, 1'b1, 1'b0);
        check("lit_second_hit", 32'(lives), 32'd1);
        idle(10);
        step(1'b0, 1'b1, 1'b0);
        check("lit_go_lives", 32'(lives), 32'd0);
        check("lit_go_flag", 32'(game_over), 32'd1);
        check("lit_go_display", 32'(display), 32'(D0));
        check("lit_go_inv", 32'(invulnerable), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("lit_go_sticky", 32'(lives), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        check("lit_restart_lives", 32'(lives), 32'd3);
        check("lit_restart_go", 32'(game_over), 32'd0);

        // 6. asynchronous reset in the middle of a window
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        check("lit_pre_reset_inv", 32'(invulnerable), 32'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("lit_async_lives", 32'(lives), 32'd3);
        check("lit_async_inv", 32'(invulnerable), 32'd0);
        check("lit_async_display", 32'(display), 32'(D3));
        check("lit_async_lost", 32'(life_lost), 32'd0);
        #3;
        reset = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        check("lit_start_hit_lives", 32'(lives), 32'd3);
        check("lit_start_hit_lost", 32'(life_lost), 32'd0);
        check("lit_start_hit_inv", 32'(invulnerable), 32'd0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
